// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - I2S serial receiver with clk-domain sample FIFO
// Optional macro I2S_RX_OVERFLOW_COUNT_EN enables the 16-bit dropped-word counter.
module i2s_receiver #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        i2s_clock,
  input  logic        i2s_lr,
  input  logic        i2s_data,
  output logic [23:0] audio_data,
  output logic        audio_lr_bit,
  output logic        audio_data_valid,
  input  logic        audio_data_ack,
  output logic        overflow,
  output logic [15:0] overflow_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  logic [1:0]  clk_sync;
  logic [1:0]  lr_sync;
  logic [1:0]  data_sync;
  logic        clk_prev;
  logic        strobe;
  logic        lr_s;
  logic        data_s;

  state_t      state;
  logic        lr_prev;
  logic        prev_valid;
  logic [23:0] shift;
  logic [4:0]  bit_count;
  logic [23:0] shift_next;
  logic [4:0]  bit_idx;
  logic        lr_change;
  logic        push;
  logic [24:0] push_word;

  logic [24:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic        full;
  logic        pop;
  logic        wr_en;
  logic [24:0] head;

  // Data and word select share the bit clock's synchronizer depth so they stay aligned to the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b00;
      lr_sync   <= 2'b00;
      data_sync <= 2'b00;
      clk_prev  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], i2s_clock};
      lr_sync   <= {lr_sync[0], i2s_lr};
      data_sync <= {data_sync[0], i2s_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign strobe = clk_sync[1] & ~clk_prev;
  assign lr_s   = lr_sync[1];
  assign data_s = data_sync[1];

  always_comb begin
    shift_next = shift;
    bit_idx    = 5'd23 - bit_count;
    if (bit_count < 5'd24) begin
      shift_next[bit_idx] = data_s;
    end
  end

  // The bit sampled on an LR change still belongs to the previous word (one-bit I2S delay).
  assign lr_change = (lr_s != lr_prev);
  assign push      = enable && (state == RUN) && strobe && lr_change;
  assign push_word = {lr_prev, shift_next};

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state      <= IDLE;
      lr_prev    <= 1'b0;
      prev_valid <= 1'b0;
      shift      <= 24'h0;
      bit_count  <= 5'd0;
    end else begin
      case (state)
        IDLE: state <= SYNC;
        SYNC: begin
          if (strobe) begin
            lr_prev    <= lr_s;
            prev_valid <= 1'b1;
            if (prev_valid && lr_change) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (strobe) begin
            lr_prev <= lr_s;
            if (lr_change) begin
              shift     <= 24'h0;
              bit_count <= 5'd0;
            end else begin
              shift <= shift_next;
              if (bit_count < 5'd24) begin
                bit_count <= bit_count + 5'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign count            = wr_ptr - rd_ptr;
  assign full             = (count == DEPTH_W);
  assign audio_data_valid = (count != '0);
  assign pop              = audio_data_valid && audio_data_ack;
  assign wr_en            = push && (!full || pop) && !rst;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end else if (push) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef I2S_RX_OVERFLOW_COUNT_EN
  logic [15:0] ovf_cnt;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      ovf_cnt <= 16'h0;
    end else if (push && full && !pop && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  assign overflow_count = ovf_cnt;
`else
  assign overflow_count = 16'h0;
`endif

  // Head is masked while empty so flushed or never-written entries never reach the outputs.
  assign head         = mem[rd_ptr[AW-1:0]];
  assign audio_data   = audio_data_valid ? head[23:0] : 24'h0;
  assign audio_lr_bit = audio_data_valid & head[24];

endmodule
